dvp_frame_gen: RTL and testbench

//  Synthesizable OV7670-style DVP source: generates pclk, href, vsync and an 8-bit pixel bus.

---
 rtl/dvp_gen_pkg.sv | 36 +++
 rtl/dvp_pclk_div.sv | 46 ++++
 rtl/dvp_frame_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_gen_pkg
//  Brief    : Shared encodings for the DVP frame generator: FSM states,
//             pattern mode codes, chroma constant and LFSR parameters.
//  Revision : 1.0 - initial release
// ============================================================================
package dvp_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VS   = 3'd1,
    ST_VBP  = 3'd2,
    ST_ACT  = 3'd3,
    ST_HBL  = 3'd4,
    ST_VFP  = 3'd5
  } state_e;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  // Byte carried in the odd (UV) slot when two bytes per pixel are sent
  localparam logic [7:0] CHROMA = 8'h80;

  // Galois LFSR, taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pclk_div.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pclk_div
//  Brief    : Divides clk into a 50% duty pclk (CLK_DIV clk per half period)
//             and flags the clk cycle whose edge takes pclk from 1 to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_hw,
  output logic pclk,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pclk_q, pclk_d;
  logic             wrap;

  // Half-period counter; pclk toggles when the counter wraps
  always_comb begin
    wrap   = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    pclk_d = wrap ? ~pclk_q : pclk_q;
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst_hw) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

  // Strobe is high in the cycle whose closing edge drops pclk
  assign fall_tick = wrap & pclk_q;
  assign pclk      = pclk_q;

endmodule
`default_nettype wire

// File: rtl/dvp_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_frame_gen
//  Brief    : OV7670-style DVP source (pclk/href/vsync/pixel) with a run-time
//             selectable test pattern, used in place of the camera pins.
//  Config   : define DVP_GEN_LFSR_EN to make mode 3 an LFSR pattern;
//             otherwise mode 3 produces the ramp.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_frame_gen
  import dvp_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 10,
  parameter int V_ACTIVE    = 4,
  parameter int H_BLANK     = 1,
  parameter int VSYNC_LINES = 1,
  parameter int V_BACK      = 1,
  parameter int V_FRONT     = 1,
  parameter int BPP         = 2,
  parameter int CLK_DIV     = 2
) (
  input  logic       clk,
  input  logic       rst_hw,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] const_val,
  output logic       pclk,
  output logic       href,
  output logic       vsync,
  output logic [7:0] pixel,
  output logic       frame_done,
  output logic       busy
);

  localparam int ACT_LEN  = H_ACTIVE * BPP;
  localparam int LINE_LEN = ACT_LEN + H_BLANK;
  localparam int VMAX     = (VSYNC_LINES > V_BACK)
                          ? ((VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT)
                          : ((V_BACK > V_FRONT) ? V_BACK : V_FRONT);
  localparam int HW = $clog2(LINE_LEN + 1);
  localparam int CW = $clog2(ACT_LEN + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam int VW = $clog2(VMAX + 1);

  logic fall_tick;

  dvp_pclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pclk_div (
    .clk       (clk),
    .rst_hw    (rst_hw),
    .pclk      (pclk),
    .fall_tick (fall_tick)
  );

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;     // pclk period index within the line
  logic [VW-1:0]   vcnt_q, vcnt_d;     // line index within VS/VBP/VFP
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            phase_q, phase_d;   // 1 while presenting the chroma byte
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      cval_q, cval_d;
  logic            href_q, href_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      pixel_q, pixel_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_start;
  logic            line_end;
  logic [7:0]      y_val;

`ifdef DVP_GEN_LFSR_EN
  logic [15:0]     lfsr_q, lfsr_d;
`endif

  // Frame/line sequencing; everything advances only on the pclk falling edge
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    row_d        = row_q;
    col_d        = col_q;
    phase_d      = phase_q;
    mode_d       = mode_q;
    cval_d       = cval_q;
    href_d       = href_q;
    vsync_d      = vsync_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;
    line_end     = (hcnt_q == HW'(LINE_LEN - 1));

    if (fall_tick) begin
      if (state_q != ST_IDLE) begin
        hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) frame_start = 1'b1;
        end
        ST_VS: begin
          if (line_end) begin
            if (vcnt_q == VW'(VSYNC_LINES - 1)) begin
              state_d = ST_VBP;
              vcnt_d  = '0;
              vsync_d = 1'b0;
            end else begin
              vcnt_d = vcnt_q + VW'(1);
            end
          end
        end
        ST_VBP: begin
          if (line_end) begin
            if (vcnt_q == VW'(V_BACK - 1)) begin
              state_d = ST_ACT;
              row_d   = '0;
              col_d   = '0;
              phase_d = 1'b0;
              href_d  = 1'b1;
            end else begin
              vcnt_d = vcnt_q + VW'(1);
            end
          end
        end
        ST_ACT: begin
          if (hcnt_q == HW'(ACT_LEN - 1)) begin
            state_d = ST_HBL;
            href_d  = 1'b0;
          end else if ((BPP == 2) && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            col_d   = col_q + CW'(1);
          end
        end
        ST_HBL: begin
          if (line_end) begin
            if (row_q == RW'(V_ACTIVE - 1)) begin
              state_d = ST_VFP;
              vcnt_d  = '0;
            end else begin
              state_d = ST_ACT;
              row_d   = row_q + RW'(1);
              col_d   = '0;
              phase_d = 1'b0;
              href_d  = 1'b1;
            end
          end
        end
        ST_VFP: begin
          if (line_end) begin
            if (vcnt_q == VW'(V_FRONT - 1)) begin
              frame_done_d = 1'b1;
              if (enable) frame_start = 1'b1;
              else        state_d     = ST_IDLE;
            end else begin
              vcnt_d = vcnt_q + VW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Pattern controls are latched once per frame
      if (frame_start) begin
        state_d = ST_VS;
        vcnt_d  = '0;
        hcnt_d  = '0;
        vsync_d = 1'b1;
        mode_d  = mode;
        cval_d  = const_val;
      end
    end
  end

  // Luma value for the byte being launched (uses the next row/col)
  always_comb begin
    y_val = 8'(32'(row_d) * 32'(H_ACTIVE) + 32'(col_d));
    case (mode_q)
      MODE_CONST: y_val = cval_q;
      MODE_CHECK: y_val = (((32'(row_d) ^ 32'(col_d)) & 32'd8) != 32'd0) ? 8'hFF : 8'h00;
`ifdef DVP_GEN_LFSR_EN
      MODE_LFSR:  y_val = lfsr_q[7:0];
`endif
      default: ;
    endcase
  end

  // Output byte: Y or chroma inside the href window, zero outside it
  always_comb begin
    pixel_d = pixel_q;
    if (fall_tick) begin
      if (href_d) pixel_d = phase_d ? CHROMA : y_val;
      else        pixel_d = 8'h00;
    end
  end

`ifdef DVP_GEN_LFSR_EN
  // LFSR restarts every frame and advances once per Y byte emitted
  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_start)                           lfsr_d = LFSR_SEED;
    else if (fall_tick && href_d && !phase_d)  lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (rst_hw) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_hw) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      phase_q      <= 1'b0;
      mode_q       <= MODE_RAMP;
      cval_q       <= 8'h00;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      pixel_q      <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      cval_q       <= cval_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign href       = href_q;
  assign vsync      = vsync_q;
  assign pixel      = pixel_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_frame_gen
//  Brief    : Self-checking bench for dvp_frame_gen; one instance with one
//             byte per pixel and one with two, sharing all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_frame_gen;

  logic       clk = 1'b0;
  logic       rst_hw, enable;
  logic [1:0] mode;
  logic [7:0] const_val;

  logic       pclk1, href1, vsync1, frame_done1, busy1;
  logic [7:0] pixel1;
  logic       pclk2, href2, vsync2, frame_done2, busy2;
  logic [7:0] pixel2;

  always #5 clk = ~clk;

  dvp_frame_gen #(.BPP(1)) u_dut1 (
    .clk(clk), .rst_hw(rst_hw), .enable(enable), .mode(mode), .const_val(const_val),
    .pclk(pclk1), .href(href1), .vsync(vsync1), .pixel(pixel1),
    .frame_done(frame_done1), .busy(busy1)
  );

  dvp_frame_gen #(.BPP(2)) u_dut2 (
    .clk(clk), .rst_hw(rst_hw), .enable(enable), .mode(mode), .const_val(const_val),
    .pclk(pclk2), .href(href2), .vsync(vsync2), .pixel(pixel2),
    .frame_done(frame_done2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;

  // Per-instance capture of the bytes seen at pclk rise, organised by line
  logic       pc [2];
  logic       hr [2];
  logic       vs [2];
  logic       fd [2];
  logic [7:0] px [2];
  logic       pp [2] = '{1'b0, 1'b0};
  logic       hp [2] = '{1'b0, 1'b0};
  logic       vp [2] = '{1'b0, 1'b0};
  logic [7:0] cur  [2][4][20];
  logic [7:0] last [2][4][20];
  int         len_cur  [2][4];
  int         len_last [2][4];
  int         rowp [2] = '{0, 0};
  int         colp [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};

  always_comb begin
    pc[0] = pclk1; hr[0] = href1; vs[0] = vsync1; fd[0] = frame_done1; px[0] = pixel1;
    pc[1] = pclk2; hr[1] = href2; vs[1] = vsync2; fd[1] = frame_done2; px[1] = pixel2;
  end

  // Capture monitor
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fd[d]) begin
        for (int r = 0; r < 4; r++) begin
          len_last[d][r] = len_cur[d][r];
          for (int c = 0; c < 20; c++) last[d][r][c] = cur[d][r][c];
        end
        done_cnt[d]++;
      end
      if (vs[d] && !vp[d]) begin
        rowp[d] = 0;
        colp[d] = 0;
        for (int r = 0; r < 4; r++) begin
          len_cur[d][r] = 0;
          for (int c = 0; c < 20; c++) cur[d][r][c] = 8'h00;
        end
      end
      if (pc[d] && !pp[d] && hr[d]) begin
        if (rowp[d] < 4 && colp[d] < 20) cur[d][rowp[d]][colp[d]] = px[d];
        colp[d]++;
      end
      if (!hr[d] && hp[d]) begin
        if (rowp[d] < 4) len_cur[d][rowp[d]] = colp[d];
        rowp[d]++;
        colp[d] = 0;
      end
      pp[d] = pc[d];
      hp[d] = hr[d];
      vp[d] = vs[d];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return vsync1;
      1:       return href1;
      default: return frame_done1;
    endcase
  endfunction

  // Wait until the selected dut1 signal reaches lvl; returns clk cycles taken
  task automatic wait_level(input int sel, input logic lvl, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL wait_level sel%0d: no level %0d after %0d clk", sel, lvl, n);
    end
  endtask

  task automatic wait_frames(input int n, input logic both);
    int c0, c1, t;
    c0 = done_cnt[0];
    c1 = done_cnt[1];
    t  = 0;
    while (!((done_cnt[0] >= c0 + n) && (!both || done_cnt[1] >= c1 + n)) && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      tests++;
      fails++;
      $display("FAIL wait_frames: %0d clk elapsed, needed %0d frames", t, n);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cval;
    int         d;
    int         row;
    int         idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, n2, bad, hcnt, dones, vs_hi, busy_hi;
    logic seen;

    // mode, const, instance (0: 1 byte/pixel, 1: 2 bytes/pixel), row, byte index, expected byte
    vecs[0]  = '{2'd0, 8'h00, 0, 0, 0,  8'd0};
    vecs[1]  = '{2'd0, 8'h00, 0, 0, 9,  8'd9};
    vecs[2]  = '{2'd0, 8'h00, 0, 1, 0,  8'd10};
    vecs[3]  = '{2'd0, 8'h00, 0, 1, 9,  8'd19};
    vecs[4]  = '{2'd0, 8'h00, 0, 3, 9,  8'd39};
    vecs[5]  = '{2'd0, 8'h00, 0, 2, 5,  8'd25};
    vecs[6]  = '{2'd0, 8'h00, 1, 1, 0,  8'd10};
    vecs[7]  = '{2'd0, 8'h00, 1, 1, 1,  8'h80};
    vecs[8]  = '{2'd0, 8'h00, 1, 1, 18, 8'd19};
    vecs[9]  = '{2'd0, 8'h00, 1, 1, 19, 8'h80};
    vecs[10] = '{2'd0, 8'h00, 1, 3, 18, 8'd39};
    vecs[11] = '{2'd2, 8'h00, 0, 0, 7,  8'h00};
    vecs[12] = '{2'd2, 8'h00, 0, 0, 8,  8'hFF};
    vecs[13] = '{2'd2, 8'h00, 0, 3, 9,  8'hFF};
    vecs[14] = '{2'd2, 8'h00, 1, 2, 16, 8'hFF};
    vecs[15] = '{2'd2, 8'h00, 1, 2, 14, 8'h00};
    vecs[16] = '{2'd1, 8'hA5, 0, 2, 4,  8'hA5};
    vecs[17] = '{2'd1, 8'hA5, 1, 0, 3,  8'h80};
    vecs[18] = '{2'd1, 8'hA5, 1, 3, 18, 8'hA5};
    vecs[19] = '{2'd3, 8'h00, 0, 1, 4,  8'd14};

    rst_hw = 1'b1; enable = 1'b0; mode = 2'd0; const_val = 8'h00;
    repeat (3) tick();
    check("rst_pclk", pclk1, 1'b0);
    check("rst_href", href1, 1'b0);
    check("rst_vsync", vsync1, 1'b0);
    check("rst_pixel", pixel1, 8'h00);
    check("rst_frame_done", frame_done1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_busy_bpp2", busy2, 1'b0);
    rst_hw = 1'b0;
    enable = 1'b1;

    // Table-driven pattern checks
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].cval != vecs[i-1].cval) begin
        mode      = vecs[i].mode;
        const_val = vecs[i].cval;
        wait_frames(2, 1'b1);
      end
      check($sformatf("vec%0d_d%0d_r%0d_b%0d", i, vecs[i].d, vecs[i].row, vecs[i].idx),
            last[vecs[i].d][vecs[i].row][vecs[i].idx], vecs[i].exp);
    end

    // Line and frame timing on the one-byte instance
    mode = 2'd0;
    wait_frames(1, 1'b0);
    check("busy_running", busy1, 1'b1);
    wait_level(0, 1'b0, n);
    wait_level(0, 1'b1, n);
    wait_level(0, 1'b0, n);
    check("vsync_high_clk", n, 44);
    wait_level(1, 1'b1, n);
    wait_level(1, 1'b0, n);
    check("href_high_clk", n, 40);
    wait_level(1, 1'b1, n);
    check("href_gap_clk", n, 4);
    wait_level(2, 1'b1, n);
    wait_level(2, 1'b0, n);
    check("frame_done_width", n, 1);
    wait_level(2, 1'b1, n2);
    check("frame_done_period", n + n2, 308);
    check("line_len_bpp1", len_last[0][0], 10);
    check("line_len_bpp2", len_last[1][2], 20);

    // Constant value changed mid-frame only takes effect next frame
    mode = 2'd1; const_val = 8'h5A;
    wait_frames(2, 1'b0);
    repeat (100) tick();
    const_val = 8'h33;
    wait_frames(1, 1'b0);
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 10; c++)
        if (last[0][r][c] !== 8'h5A) bad++;
    check("const_held_5A_bad_bytes", bad, 0);
    wait_frames(1, 1'b0);
    bad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 10; c++)
        if (last[0][r][c] !== 8'h33) bad++;
    check("const_next_33_bad_bytes", bad, 0);

    // Enable dropped during row 2: frame completes, then stays idle
    mode = 2'd0;
    wait_frames(1, 1'b0);
    repeat (180) tick();
    enable = 1'b0;
    dones = 0; vs_hi = 0; busy_hi = 0; seen = 1'b0;
    for (int t = 0; t < 1300; t++) begin
      tick();
      if (frame_done1) begin dones++; seen = 1'b1; end
      if (seen && vsync1) vs_hi++;
      if (seen && busy1) busy_hi++;
    end
    check("stop_done_pulses", dones, 1);
    check("stop_vsync_high_clk", vs_hi, 0);
    check("stop_busy_high_clk", busy_hi, 0);
    check("stop_row2_first", last[0][2][0], 8'd20);
    check("stop_row3_last", last[0][3][9], 8'd39);
    check("stop_row3_len", len_last[0][3], 10);

    // Reset pulse during an active line
    enable = 1'b1;
    wait_level(1, 1'b1, n);
    repeat (3) tick();
    rst_hw = 1'b1;
    tick();
    check("midrst_href", href1, 1'b0);
    check("midrst_pixel", pixel1, 8'h00);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_pclk", pclk1, 1'b0);
    check("midrst_vsync", vsync1, 1'b0);
    rst_hw = 1'b0;
    hcnt = 0; n = 0;
    while (!vsync1 && n < 200) begin
      tick();
      n++;
      if (href1) hcnt++;
    end
    check("postrst_vsync_rise", vsync1, 1'b1);
    check("postrst_href_before_vsync", hcnt, 0);
    wait_frames(1, 1'b0);
    check("postrst_r0_p0", last[0][0][0], 8'd0);
    check("postrst_r0_p1", last[0][0][1], 8'd1);
    check("postrst_r3_p9", last[0][3][9], 8'd39);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
